// File: rtl/intc_pkg.sv
// ---------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt controller, the CPU-side interrupt
// sequencer and the core: default widths, MMIO register offsets, STATUS
// field positions and the sequencer state encoding (visible in STATUS).
// ---------------------------------------------------------------------------
package intc_pkg;

    localparam int          ADDR_W_DEF    = 32;
    localparam int          NUM_SRC_DEF   = 4;
    localparam logic [31:0] MMIO_BASE_DEF = 32'h0000_0900;

    // Word register offsets from the MMIO base.
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_MASK   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_EPC    = 4'hC;

    // STATUS layout: {.., active_src at [5:4], state at [3:1], in_isr at [0]}.
    localparam int STATUS_IN_ISR_BIT = 0;
    localparam int STATUS_STATE_LSB  = 1;
    localparam int STATUS_STATE_W    = 3;
    localparam int STATUS_SRC_LSB    = 4;

    // Encoding is software-visible through STATUS, so values are pinned.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACK    = 3'd2,
        ST_VECTOR = 3'd3,
        ST_IN_ISR = 3'd4,
        ST_RETURN = 3'd5
    } seq_state_e;

endpackage

// File: rtl/intc_seq_regs.sv
// ---------------------------------------------------------------------------
// intc_seq_regs
// MMIO register block of the interrupt sequencer: address decode, the
// CTRL (global enable) and MASK (per-source mask) registers, and the
// combinational read mux over CTRL / MASK / STATUS / EPC.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   input_addr     MMIO address
//   write_data     MMIO write data
//   write_enable   MMIO write strobe
//   status_in      packed STATUS word from the sequencer (read-only)
//   epc_in         saved return PC from the sequencer (read-only)
//   ctrl_en        CTRL[0], global interrupt enable
//   mask           per-source mask, 1 = masked
//   read_data      read data for input_addr, 0 when unmapped
// ---------------------------------------------------------------------------
module intc_seq_regs
    import intc_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                NUM_SRC   = NUM_SRC_DEF,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  input_addr,
    input  logic [ADDR_W-1:0]  write_data,
    input  logic               write_enable,
    input  logic [ADDR_W-1:0]  status_in,
    input  logic [ADDR_W-1:0]  epc_in,
    output logic               ctrl_en,
    output logic [NUM_SRC-1:0] mask,
    output logic [ADDR_W-1:0]  read_data
);

    localparam logic [ADDR_W-1:0] A_CTRL   = MMIO_BASE + ADDR_W'(OFF_CTRL);
    localparam logic [ADDR_W-1:0] A_MASK   = MMIO_BASE + ADDR_W'(OFF_MASK);
    localparam logic [ADDR_W-1:0] A_STATUS = MMIO_BASE + ADDR_W'(OFF_STATUS);
    localparam logic [ADDR_W-1:0] A_EPC    = MMIO_BASE + ADDR_W'(OFF_EPC);

    logic               ctrl_en_q, ctrl_en_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;

    // Upper write-data bits have no storage behind them.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, write_data[ADDR_W-1:NUM_SRC]};

    // STATUS and EPC decode to nothing on the write side: writes are dropped.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        ctrl_en_d = ctrl_en_q;
        mask_d    = mask_q;
        if (write_enable) begin
            if (input_addr == A_CTRL) begin
                ctrl_en_d = write_data[0];
            end
            if (input_addr == A_MASK) begin
                mask_d = write_data[NUM_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            ctrl_en_q <= 1'b0;
            mask_q    <= '1;     // every source masked out of reset
        end else begin
            ctrl_en_q <= ctrl_en_d;
            mask_q    <= mask_d;
        end
    end

    always_comb begin
        read_data = '0;
        if (input_addr == A_CTRL) begin
            read_data = ADDR_W'(ctrl_en_q);
        end else if (input_addr == A_MASK) begin
            read_data = ADDR_W'(mask_q);
        end else if (input_addr == A_STATUS) begin
            read_data = status_in;
        end else if (input_addr == A_EPC) begin
            read_data = epc_in;
        end
    end

    assign ctrl_en = ctrl_en_q;
    assign mask    = mask_q;

endmodule

// File: rtl/intc_sequencer.sv
// ---------------------------------------------------------------------------
// intc_sequencer
// CPU-side interrupt entry/exit controller between intc and the core's PC
// logic. Gates the intc IRQ with the global enable and per-source mask,
// waits for an instruction boundary, saves the return PC in EPC, pulses
// IACK, redirects the PC to the ISR vector, blocks nesting until RETI and
// then redirects the PC back to EPC.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   irq              level IRQ from intc
//   priority_select  winning source index from intc
//   isr_addr         vector of the winning source
//   iack             one-cycle acknowledge pulse to intc
//   instr_boundary   core retires an instruction this cycle
//   pc_next          PC of the next instruction (becomes EPC)
//   reti             core executes return-from-interrupt
//   pc_load          force PC := pc_target next cycle
//   pc_target        redirect target (vector or EPC)
//   in_isr           handler active, nesting blocked
//   input_addr, write_data, write_enable, read_data   MMIO port
// ---------------------------------------------------------------------------
module intc_sequencer
    import intc_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                NUM_SRC   = NUM_SRC_DEF,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEF),
    localparam int               SRC_W     = $clog2(NUM_SRC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [SRC_W-1:0]  priority_select,
    input  logic [ADDR_W-1:0] isr_addr,
    output logic              iack,
    input  logic              instr_boundary,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              reti,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              in_isr,
    input  logic [ADDR_W-1:0] input_addr,
    input  logic [ADDR_W-1:0] write_data,
    input  logic              write_enable,
    output logic [ADDR_W-1:0] read_data
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] vec_q, vec_d;
    logic [SRC_W-1:0]  active_src_q, active_src_d;
    logic              in_isr_q, in_isr_d;

    logic               ctrl_en;
    logic [NUM_SRC-1:0] mask;
    logic               take;
    logic [ADDR_W-1:0]  status;

    intc_seq_regs #(
        .ADDR_W    (ADDR_W),
        .NUM_SRC   (NUM_SRC),
        .MMIO_BASE (MMIO_BASE)
    ) u_regs (
        .clk          (clk),
        .rst          (rst),
        .input_addr   (input_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .status_in    (status),
        .epc_in       (epc_q),
        .ctrl_en      (ctrl_en),
        .mask         (mask),
        .read_data    (read_data)
    );

    assign take = irq & ctrl_en & ~mask[priority_select];

    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        vec_d        = vec_q;
        active_src_d = active_src_q;
        in_isr_d     = in_isr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!take) begin
                    state_d = ST_IDLE;
                end else if (instr_boundary) begin
                    // Source, vector and return PC are frozen on this edge;
                    // later priority changes cannot retarget the entry.
                    state_d      = ST_ACK;
                    epc_d        = pc_next;
                    active_src_d = priority_select;
                    vec_d        = isr_addr;
                end
            end
            ST_ACK: begin
                state_d = ST_VECTOR;
            end
            ST_VECTOR: begin
                state_d  = ST_IN_ISR;
                in_isr_d = 1'b1;
            end
            ST_IN_ISR: begin
                // irq is ignored here; a pending source is re-evaluated from
                // IDLE after RETURN, giving at least one idle cycle.
                if (reti) state_d = ST_RETURN;
            end
            ST_RETURN: begin
                state_d  = ST_IDLE;
                in_isr_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            epc_q        <= '0;
            vec_q        <= '0;
            active_src_q <= '0;
            in_isr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            epc_q        <= epc_d;
            vec_q        <= vec_d;
            active_src_q <= active_src_d;
            in_isr_q     <= in_isr_d;
        end
    end

    // Moore outputs: decoded from registered state only, so an async reset
    // drops iack/pc_load in the same cycle.
    always_comb begin
        iack      = (state_q == ST_ACK);
        pc_load   = (state_q == ST_VECTOR) || (state_q == ST_RETURN);
        pc_target = '0;
        if (state_q == ST_VECTOR) begin
            pc_target = vec_q;
        end else if (state_q == ST_RETURN) begin
            pc_target = epc_q;
        end
    end

    assign in_isr = in_isr_q;

    always_comb begin
        status = '0;
        status[STATUS_IN_ISR_BIT]                       = in_isr_q;
        status[STATUS_STATE_LSB +: STATUS_STATE_W]      = state_q;
        status[STATUS_SRC_LSB +: SRC_W]                 = active_src_q;
    end

endmodule
